// File: rtl/img_arb_pkg.sv
// Shared constants, types and the round-robin pick helper for the image memory arbiter.
// Latency: n/a (declarations and a pure combinational function).
// Backpressure: n/a.
package img_arb_pkg;

    localparam int IMG_DATA_W       = 8;
    localparam int IMG_ADDR_W_DEF   = 12;
    localparam int IMG_LOCK_MAX_DEF = 4;

    // Widest requester vector rr_pick handles; narrower users zero-extend.
    localparam int RR_MAX   = 8;
    localparam int RR_PTR_W = 3;

    typedef enum logic {
        LK_IDLE = 1'b0,
        LK_HELD = 1'b1
    } lock_state_t;

    // One-hot grant of the first set request at or after ptr, wrapping at n.
    function automatic logic [RR_MAX-1:0] rr_pick(
        input logic [RR_MAX-1:0]   req,
        input logic [RR_PTR_W-1:0] ptr,
        input int                  n
    );
        logic [RR_MAX-1:0] gnt;
        logic [3:0]        idx;
        logic              found;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < RR_MAX; i++) begin
            // ptr < n and i < n, so one conditional subtract wraps the index.
            idx = {1'b0, ptr} + 4'(i);
            if (idx >= 4'(n)) begin
                idx = idx - 4'(n);
            end
            if ((i < n) && !found && req[idx[2:0]]) begin
                gnt[idx[2:0]] = 1'b1;
                found         = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick plus a registered priority pointer.
// Latency: grant is combinational from req; the pointer moves on the next clock when adv_en.
// Backpressure: none internally; callers mask req or gate the grant as needed.
module rr_arbiter
    import img_arb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         adv_en,
    input  logic [N-1:0] adv_sel,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]       ptr_q;
    logic [PW-1:0]       ptr_d;
    logic [RR_MAX-1:0]   req_ext;
    logic [RR_PTR_W-1:0] ptr_ext;
    logic [RR_MAX-1:0]   pick;

    // Widen to the helper's fixed width and pick the next requester.
    always_comb begin
        req_ext           = '0;
        req_ext[N-1:0]    = req;
        ptr_ext           = '0;
        ptr_ext[PW-1:0]   = ptr_q;
        pick              = rr_pick(req_ext, ptr_ext, N);
        gnt               = pick[N-1:0];
    end

    // Move priority to the slot just after the one named by adv_sel.
    always_comb begin
        ptr_d = ptr_q;
        if (adv_en) begin
            for (int i = 0; i < N; i++) begin
                if (adv_sel[i]) begin
                    ptr_d = (i == N - 1) ? '0 : PW'(i + 1);
                end
            end
        end
    end

    // Pointer register; requester 0 has priority out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/img_mem_arb.sv
// Shares one 1R1W image memory among read/write requesters: RR per port, read burst lock, RAW hazard stall.
// Latency: grants combinational in cycle t; read data returned with a one-hot rd_valid in t+1.
// Backpressure: an ungranted requester holds req/addr; same-address reads stall behind the write.
// Optional IMG_ARB_STATS_EN adds grant/stall counters and a synchronous stat_clr.
module img_mem_arb
    import img_arb_pkg::*;
#(
    parameter int ADDR_W   = IMG_ADDR_W_DEF,
    parameter int N_RD     = 3,
    parameter int N_WR     = 2,
    parameter int LOCK_MAX = IMG_LOCK_MAX_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_RD-1:0]              rd_req,
    input  logic [N_RD*ADDR_W-1:0]       rd_addr,
    input  logic [N_RD-1:0]              rd_lock,
    output logic [N_RD-1:0]              rd_gnt,
    output logic [N_RD-1:0]              rd_valid,
    output logic [IMG_DATA_W-1:0]        rd_data,
    input  logic [N_WR-1:0]              wr_req,
    input  logic [N_WR*ADDR_W-1:0]       wr_addr,
    input  logic [N_WR*IMG_DATA_W-1:0]   wr_data,
    output logic [N_WR-1:0]              wr_gnt,
    output logic [ADDR_W-1:0]            mem_raddr,
    input  logic [IMG_DATA_W-1:0]        mem_rdata,
    output logic [ADDR_W-1:0]            mem_waddr,
    output logic [IMG_DATA_W-1:0]        mem_wdata,
    output logic                         mem_we
`ifdef IMG_ARB_STATS_EN
    ,
    input  logic                         stat_clr,
    output logic [31:0]                  stat_rd_grants,
    output logic [31:0]                  stat_wr_grants,
    output logic [15:0]                  stat_hazard_stalls
`endif
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    logic [N_RD-1:0]   rd_arb_req;
    logic [N_RD-1:0]   rd_pick;
    logic [N_WR-1:0]   wr_pick;
    logic [ADDR_W-1:0] rd_win_addr;
    logic              hazard;
    logic              rd_adv_en;
    logic [N_RD-1:0]   rd_adv_sel;

    lock_state_t       lk_state_q, lk_state_d;
    logic [N_RD-1:0]   lk_owner_q, lk_owner_d;
    logic [CNT_W-1:0]  lk_cnt_q, lk_cnt_d;
    logic [N_RD-1:0]   rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;

    // While a lock is held, only the owner's request reaches the arbiter.
    always_comb begin
        rd_arb_req = (lk_state_q == LK_HELD) ? (rd_req & lk_owner_q) : rd_req;
    end

    rr_arbiter #(.N(N_RD)) u_rd_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (rd_arb_req),
        .adv_en  (rd_adv_en),
        .adv_sel (rd_adv_sel),
        .gnt     (rd_pick)
    );

    rr_arbiter #(.N(N_WR)) u_wr_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (wr_req),
        .adv_en  (|wr_gnt),
        .adv_sel (wr_gnt),
        .gnt     (wr_pick)
    );

    // Write port: winner drives the memory write bus, idle bus parks at zero.
    always_comb begin
        wr_gnt    = rst ? '0 : wr_pick;
        mem_we    = |wr_gnt;
        mem_waddr = '0;
        mem_wdata = '0;
        for (int i = 0; i < N_WR; i++) begin
            if (wr_gnt[i]) begin
                mem_waddr = wr_addr[i*ADDR_W +: ADDR_W];
                mem_wdata = wr_data[i*IMG_DATA_W +: IMG_DATA_W];
            end
        end
    end

    // Read port: stall the winner if it hits this cycle's write address; otherwise hold the last address.
    always_comb begin
        rd_win_addr = '0;
        for (int i = 0; i < N_RD; i++) begin
            if (rd_pick[i]) begin
                rd_win_addr = rd_addr[i*ADDR_W +: ADDR_W];
            end
        end
        hazard     = mem_we && (|rd_pick) && (rd_win_addr == mem_waddr);
        rd_gnt     = (rst || hazard) ? '0 : rd_pick;
        mem_raddr  = (|rd_gnt) ? rd_win_addr : raddr_q;
        raddr_d    = mem_raddr;
        rd_valid_d = rd_gnt;
    end

    // Memory has one cycle of read latency, so its output lines up with the valid pipe.
    assign rd_valid = rd_valid_q;
    assign rd_data  = mem_rdata;

    // Burst lock: track owner and grant count, release on unlock, count limit or dropped request.
    always_comb begin
        lk_state_d = lk_state_q;
        lk_owner_d = lk_owner_q;
        lk_cnt_d   = lk_cnt_q;
        rd_adv_en  = |rd_gnt;
        rd_adv_sel = rd_gnt;
        if (lk_state_q == LK_IDLE) begin
            // With a limit of one, the very grant that asks for the lock exhausts it.
            if ((|(rd_gnt & rd_lock)) && (LOCK_MAX > 1)) begin
                lk_state_d = LK_HELD;
                lk_owner_d = rd_gnt;
                lk_cnt_d   = CNT_W'(1);
            end
        end else begin
            if (!(|(rd_req & lk_owner_q))) begin
                // Owner walked away without a grant: still hand priority past it.
                lk_state_d = LK_IDLE;
                lk_owner_d = '0;
                lk_cnt_d   = '0;
                rd_adv_en  = 1'b1;
                rd_adv_sel = lk_owner_q;
            end else if (|rd_gnt) begin
                if (!(|(rd_lock & lk_owner_q)) || (lk_cnt_q == CNT_W'(LOCK_MAX - 1))) begin
                    lk_state_d = LK_IDLE;
                    lk_owner_d = '0;
                    lk_cnt_d   = '0;
                end else begin
                    lk_cnt_d = lk_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Lock state, read-valid pipe and read-address shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lk_state_q <= LK_IDLE;
            lk_owner_q <= '0;
            lk_cnt_q   <= '0;
            rd_valid_q <= '0;
            raddr_q    <= '0;
        end else begin
            lk_state_q <= lk_state_d;
            lk_owner_q <= lk_owner_d;
            lk_cnt_q   <= lk_cnt_d;
            rd_valid_q <= rd_valid_d;
            raddr_q    <= raddr_d;
        end
    end

`ifdef IMG_ARB_STATS_EN
    logic [31:0] st_rd_q, st_rd_d;
    logic [31:0] st_wr_q, st_wr_d;
    logic [15:0] st_hz_q, st_hz_d;

    // Grant counters wrap; the stall counter saturates.
    always_comb begin
        st_rd_d = st_rd_q;
        st_wr_d = st_wr_q;
        st_hz_d = st_hz_q;
        if (stat_clr) begin
            st_rd_d = '0;
            st_wr_d = '0;
            st_hz_d = '0;
        end else begin
            if (|rd_gnt) begin
                st_rd_d = st_rd_q + 32'd1;
            end
            if (mem_we) begin
                st_wr_d = st_wr_q + 32'd1;
            end
            if (hazard && (st_hz_q != 16'hFFFF)) begin
                st_hz_d = st_hz_q + 16'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_rd_q <= '0;
            st_wr_q <= '0;
            st_hz_q <= '0;
        end else begin
            st_rd_q <= st_rd_d;
            st_wr_q <= st_wr_d;
            st_hz_q <= st_hz_d;
        end
    end

    assign stat_rd_grants     = st_rd_q;
    assign stat_wr_grants     = st_wr_q;
    assign stat_hazard_stalls = st_hz_q;
`endif

endmodule

// File: doc/img_mem_arb.md
Name: img_mem_arb

Overview:
- Arbiter/scheduler that shares one `onchip_mem_img` instance (1 read port, 1 write port, 1-cycle read latency) between several requesters in the bilinear DSA path.
- Requesters include the interpolation engine, host readout and the loader.
- Round-robin fairness per port, optional burst lock for 2x2 neighbourhood fetches, and read/write same-address hazard stalling.
- Returns read data with a per-requester valid pulse.

Parameters:
- ADDR_W, 12, memory address width (matches the memory instance).
- N_RD, 3, number of read requesters (2..8).
- N_WR, 2, number of write requesters (1..8).
- LOCK_MAX, 4, maximum consecutive grants one read requester may hold under lock (1..16).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous active-high reset.
- rd_req  in  N_RD  per-requester read request.
- rd_addr  in  N_RD*ADDR_W  packed read addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- rd_lock  in  N_RD  hold grant for the next request of the same requester.
- rd_gnt  out  N_RD  one-hot; request accepted this cycle.
- rd_valid  out  N_RD  one-hot; rd_data valid for that requester.
- rd_data  out  8  shared read data.
- wr_req  in  N_WR  per-requester write request.
- wr_addr  in  N_WR*ADDR_W  packed write addresses.
- wr_data  in  N_WR*8  packed write data.
- wr_gnt  out  N_WR  one-hot; write performed at the end of this cycle.
- mem_raddr  out  ADDR_W  to memory read address.
- mem_rdata  in  8  from memory read data.
- mem_waddr  out  ADDR_W  to memory write address.
- mem_wdata  out  8  to memory write data.
- mem_we  out  1  to memory write enable.

Behaviour:
- Reset (async, rst=1):
  - rd_valid=0.
  - Read and write RR pointers = 0 (requester 0 highest priority).
  - Lock owner cleared, lock counter=0.
  - rd_gnt, wr_gnt, mem_we are forced 0 while rst=1.
- Arbitration is combinational in cycle t. State (pointers, lock, valid pipe) is registered.
- Write port:
  - RR among wr_req starting at wr_ptr.
  - Winner w: wr_gnt[w]=1, mem_we=1, mem_waddr/mem_wdata = w's fields.
  - After a grant, wr_ptr = w+1 mod N_WR.
  - No requests: mem_we=0, mem_waddr/mem_wdata hold 0.
- Read port:
  - RR among rd_req starting at rd_ptr.
  - Winner r drives mem_raddr, and rd_gnt[r]=1.
  - No winner: mem_raddr holds its last value; this is a registered shadow of the last granted address, 0 after reset.
- Read latency: grant in cycle t, then rd_valid[r]=1 in cycle t+1 with rd_data = mem_rdata. Exactly one pulse per grant.
- Back-to-back grants sustain 1 read/cycle.
- Hazard: if a write is granted to address A and the read winner also targets A in the same cycle:
  - The read is NOT granted that cycle; rd_gnt=0 and the pointer is unchanged.
  - The requester retries and reads the new data in t+1.
  - A read of a different address proceeds in parallel.
- Lock:
  - If rd_lock[r]=1 at grant, r becomes owner and the lock counter increments.
  - While an owner exists, only the owner may be granted; other requests wait, even if the owner is idle.
  - The lock ends when any of these occurs: the owner is granted with rd_lock=0; the counter reaches LOCK_MAX; or the owner drops rd_req.
  - On lock end: rd_ptr = owner+1, counter = 0.
  - The LOCK_MAX forced release takes effect after the LOCK_MAX-th grant. The next cycle re-arbitrates RR, so another requester gets at least one grant before the owner can re-lock.
- Pointer update without lock: rd_ptr = r+1 mod N_RD on each grant.
- Requesters must hold rd_req/rd_addr stable until rd_gnt. A request withdrawn before its grant is simply dropped.
- Reset mid-operation: a pending rd_valid pulse is discarded; lock state is cleared.

Optional Feature:
- IMG_ARB_STATS_EN defined: adds outputs stat_rd_grants (32 bits, total read grants), stat_wr_grants (32 bits) and stat_hazard_stalls (16 bits, saturating), plus input stat_clr (synchronous clear).
  - All three counters reset to 0.
  - The 32-bit counters wrap.
- Not defined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package `img_arb_pkg`:
  - IMG_DATA_W=8.
  - Default ADDR_W / LOCK_MAX constants.
  - Function `rr_pick(req, ptr)` returning a one-hot vector.
  - typedef lock_state_t {LK_IDLE, LK_HELD}.
- Sub-module `rr_arbiter`: parameterised N, combinational pick plus registered pointer with an update-enable input. Instantiated once for read, once for write. Lock logic lives in `img_mem_arb`.

Test Plan:
- Reset then all 3 readers requesting continuously at addrs 0x010/0x020/0x030 -> grants rotate 0,1,2,0…; each rd_valid arrives 1 cycle after its grant with the matching preloaded byte.
- Writer 0 writes 0xAA to 0x100 while reader 1 reads 0x100 in the same cycle -> read stalled (rd_gnt=0); granted next cycle; rd_valid shows 0xAA; hazard stat = 1 if enabled.
- Reader 0 holds rd_lock with LOCK_MAX=4 and reader 2 requesting -> reader 0 gets 4 consecutive grants, reader 2 is granted on cycle 5.
- Two writers requesting simultaneously for 4 cycles -> wr_gnt alternates 0,1,0,1; memory contains both writers' data at their addresses.
- Assert rst one cycle after a read grant -> rd_valid stays 0, lock cleared; after release, requester 0 wins the first arbitration.
- Idle bus (no requests) for 10 cycles -> mem_we=0, no rd_valid, mem_raddr unchanged.
